// File: rtl/serial_logic_unit_pkg.sv
// Shared definitions for the bit-serial logic unit: gate select encodings and FSM states.
package serial_logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_logic_unit_if.sv
// Operand-in / result-out handshake bundle of the bit-serial logic unit.
interface serial_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/serial_logic_unit_bit_gate_sel.sv
// Single-bit gate primitives and the op-selected mux that picks one of their outputs.
module gate_and (input logic x, input logic y, output logic g);
  assign g = x & y;
endmodule

module gate_or (input logic x, input logic y, output logic g);
  assign g = x | y;
endmodule

module gate_not (input logic x, output logic g);
  assign g = ~x;
endmodule

module gate_nand (input logic x, input logic y, output logic g);
  assign g = ~(x & y);
endmodule

module gate_nor (input logic x, input logic y, output logic g);
  assign g = ~(x | y);
endmodule

module gate_xor (input logic x, input logic y, output logic g);
  assign g = x ^ y;
endmodule

module gate_xnor (input logic x, input logic y, output logic g);
  assign g = ~(x ^ y);
endmodule

module gate_buf (input logic x, output logic g);
  assign g = x;
endmodule

module bit_gate_sel
  import serial_logic_unit_pkg::*;
(
  input  logic [2:0] op,
  input  logic       x,
  input  logic       y,
  output logic       g
);
  logic and_s, or_s, not_s, nand_s, nor_s, xor_s, xnor_s, buf_s;

  gate_and  u_and  (.x(x), .y(y), .g(and_s));
  gate_or   u_or   (.x(x), .y(y), .g(or_s));
  gate_not  u_not  (.x(x),        .g(not_s));
  gate_nand u_nand (.x(x), .y(y), .g(nand_s));
  gate_nor  u_nor  (.x(x), .y(y), .g(nor_s));
  gate_xor  u_xor  (.x(x), .y(y), .g(xor_s));
  gate_xnor u_xnor (.x(x), .y(y), .g(xnor_s));
  gate_buf  u_buf  (.x(x),        .g(buf_s));

  // 8:1 output mux on the gate select
  always_comb begin
    g = 1'b0;
    case (op)
      OP_AND:  g = and_s;
      OP_OR:   g = or_s;
      OP_NOT:  g = not_s;
      OP_NAND: g = nand_s;
      OP_NOR:  g = nor_s;
      OP_XOR:  g = xor_s;
      OP_XNOR: g = xnor_s;
      OP_BUF:  g = buf_s;
      default: g = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_logic_unit.sv
// Bit-serial word logic unit: shifts operands LSB first through one gate, one bit per clock,
// and presents the assembled word with a zero flag over a valid/ready handshake.
module serial_logic_unit
  import serial_logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_logic_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, result_r, result_next_s;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             g_s, last_bit_s;
  logic             in_ready_r, out_valid_r, zero_r, busy_r;

  bit_gate_sel u_gate (
    .op (op_r),
    .x  (a_sh_r[0]),
    .y  (b_sh_r[0]),
    .g  (g_s)
  );

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    last_bit_s   = (cnt_r == CNT_W'(WIDTH - 1));
    case (state_r)
      ST_IDLE: begin
        if (bus.in_valid) state_next_s = ST_SHIFT;
        else              state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (last_bit_s) state_next_s = ST_DONE;
        else            state_next_s = ST_SHIFT;
      end
      ST_DONE: begin
        if (bus.out_ready) state_next_s = ST_IDLE;
        else               state_next_s = ST_DONE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // New gate bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps
  always_comb begin
    result_next_s            = result_r >> 1;
    result_next_s[WIDTH-1]   = g_s;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Operand capture, shift registers, bit counter and result assembly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      op_r     <= 3'd0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sh_r   <= bus.a;
            b_sh_r   <= bus.b;
            op_r     <= bus.op;
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
          end
        end
        ST_SHIFT: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          result_r <= result_next_s;
          cnt_r    <= cnt_r + CNT_W'(1);
        end
        ST_DONE:  ;
        default:  ;
      endcase
    end
  end

  // Handshake and status outputs, registered from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_next_s == ST_IDLE);
      out_valid_r <= (state_next_s == ST_DONE);
      busy_r      <= (state_next_s != ST_IDLE);
      if (state_r == ST_SHIFT && last_bit_s) zero_r <= (result_next_s == {WIDTH{1'b0}});
      else if (state_next_s == ST_DONE)      zero_r <= zero_r;
      else                                   zero_r <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.zero      = zero_r;
  assign bus.result    = result_r;
endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed bench for serial_logic_unit with a word-level reference model checked every cycle.
module tb_serial_logic_unit;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  // model state: phase 0 idle, 1 shifting, 2 result presented
  int         m_phase = 0;
  int         m_k = 0;
  logic [7:0] m_exp = 8'h00;

  serial_logic_unit_if #(.WIDTH(W)) bus ();

  serial_logic_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] word_gate(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~x;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return x ^ y;
      3'd6:    return ~(x ^ y);
      3'd7:    return x;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model advances on every rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             m_phase = 1;
             m_k     = 0;
             m_exp   = word_gate(bus.op, bus.a, bus.b);
           end
        1: begin
             m_k++;
             if (m_k == W) m_phase = 2;
           end
        2: if (bus.out_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // compare DUT against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_phase == 0});
      check("busy",      {31'd0, bus.busy},      {31'd0, m_phase != 0});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == 2});
      check("zero",      {31'd0, bus.zero},      {31'd0, (m_phase == 2) && (m_exp == 8'h00)});
      if (m_phase == 2) check("result", {24'd0, bus.result}, {24'd0, m_exp});
    end
  end

  task automatic accept(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 30) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 30) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_res, input logic exp_zero,
                        input int hold, input bit disturb);
    int n = 0;
    accept(o, x, y);
    if (disturb) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #2; n++;
        bus.in_valid = ~bus.in_valid;
        bus.a = 8'hFF;
        bus.op = 3'd7;
      end
      bus.in_valid = 1'b0;
    end
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #2; n++;
    end
    check("latency", n, W);
    check("lit_result", {24'd0, bus.result}, {24'd0, exp_res});
    check("lit_zero", {31'd0, bus.zero}, {31'd0, exp_zero});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check("hold_result", {24'd0, bus.result}, {24'd0, exp_res});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    bus.out_ready = 1'b0;
    check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bit seen = 1'b0;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00; bus.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    {24'd0, bus.result},    32'h00);
    check("rst_zero",      {31'd0, bus.zero},      32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op(3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0, 5, 1'b0);
    run_op(3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1, 1'b0);
    run_op(3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 0, 1'b0);
    run_op(3'd2, 8'h3C, 8'hFF, 8'hC3, 1'b0, 2, 1'b0);
    run_op(3'd7, 8'h3C, 8'h00, 8'h3C, 1'b0, 0, 1'b0);
    run_op(3'd1, 8'h01, 8'h80, 8'h81, 1'b0, 1, 1'b1);
    run_op(3'd6, 8'hC3, 8'h5A, 8'h66, 1'b0, 0, 1'b0);

    // abandon an XNOR four bits into the shift
    accept(3'd6, 8'h12, 8'h34);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    check("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("midrst_busy",      {31'd0, bus.busy},      32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", {31'd0, seen}, 32'd0);
    run_op(3'd4, 8'h00, 8'h00, 8'hFF, 1'b0, 0, 1'b0);

    @(posedge clk); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
